// File: rtl/clk_period_meter.sv
// Receive-side monitor for a slow, asynchronous clock or toggle.
// Synchronises it, emits edge enables, measures period/high time, and flags drift and stalls.
module clk_period_meter #(
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned EXP_PERIOD = 100000000,
    parameter int unsigned TOL        = 1000,
    parameter int unsigned TIMEOUT    = 120000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             in_range,
    output logic             stalled,
    output logic             err_seen
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    localparam logic [CNT_W:0]   EXP_EXT  = EXP_PERIOD[CNT_W:0];
    localparam logic [CNT_W:0]   TOL_EXT  = TOL[CNT_W:0];
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_shadow_q, hi_shadow_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             pv_q, pv_d;
    logic             in_range_q, in_range_d;
    logic             stalled_q, stalled_d;
    logic             err_q, err_d;

    logic             rise_ev;
    logic             fall_ev;
    logic [CNT_W-1:0] cnt_inc;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]   abs_diff;
    logic             in_range_new;

    // Synchroniser chain is deliberately left out of clr so an edge in flight is not lost.
    assign sync_d  = {sync_q[1:0], clk_in};
    assign rise_ev = sync_q[1] & ~sync_q[2];
    assign fall_ev = ~sync_q[1] & sync_q[2];
    assign cnt_inc = cnt_q + CNT_W'(1);

    // One extra bit keeps the signed deviation from wrapping for any counter value.
    assign diff         = $signed({1'b0, cnt_inc}) - $signed(EXP_EXT);
    assign abs_diff     = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign in_range_new = (abs_diff <= TOL_EXT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (rise_ev) state_d = MEASURE;
                MEASURE: if (!rise_ev && (cnt_q == TMO_LAST)) state_d = STALL;
                STALL:   if (rise_ev) state_d = MEASURE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        cnt_d       = cnt_q;
        hi_shadow_d = hi_shadow_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        in_range_d  = in_range_q;
        stalled_d   = stalled_q;
        err_d       = err_q;
        rise_d      = rise_ev;
        fall_d      = fall_ev;
        pv_d        = 1'b0;

        if (clr) begin
            cnt_d       = '0;
            hi_shadow_d = '0;
            period_d    = '0;
            high_time_d = '0;
            in_range_d  = 1'b0;
            stalled_d   = 1'b0;
            err_d       = 1'b0;
            rise_d      = 1'b0;
            fall_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise_ev) begin
                        cnt_d       = '0;
                        hi_shadow_d = '0;
                    end
                end
                MEASURE: begin
                    if (rise_ev) begin
                        period_d    = cnt_inc;
                        high_time_d = hi_shadow_q;
                        pv_d        = 1'b1;
                        in_range_d  = in_range_new;
                        if (!in_range_new) err_d = 1'b1;
                        cnt_d       = '0;
                        hi_shadow_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (fall_ev) hi_shadow_d = cnt_inc;
                        if (cnt_q == TMO_LAST) begin
                            stalled_d = 1'b1;
                            err_d     = 1'b1;
                        end
                    end
                end
                STALL: begin
                    // The gap that ends a stall is not a valid period, so nothing is published.
                    if (rise_ev) begin
                        stalled_d   = 1'b0;
                        cnt_d       = '0;
                        hi_shadow_d = '0;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            hi_shadow_q <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            pv_q        <= 1'b0;
            in_range_q  <= 1'b0;
            stalled_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hi_shadow_q <= hi_shadow_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            pv_q        <= pv_d;
            in_range_q  <= in_range_d;
            stalled_q   <= stalled_d;
            err_q       <= err_d;
        end
    end

    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = pv_q;
    assign in_range     = in_range_q;
    assign stalled      = stalled_q;
    assign err_seen     = err_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: table of waveform rows plus hand-written
// sequences for stall, clear, glitch and asynchronous reset.
module tb_clk_period_meter;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             clk_in;
    logic             clr;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             in_range;
    logic             stalled;
    logic             err_seen;

    clk_period_meter #(
        .CNT_W(CNT_W),
        .EXP_PERIOD(20),
        .TOL(2),
        .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_in(clk_in),
        .clr(clr),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .period(period),
        .high_time(high_time),
        .period_valid(period_valid),
        .in_range(in_range),
        .stalled(stalled),
        .err_seen(err_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int exp_pv;
        int exp_period;
        int exp_high;
        int exp_in_range;
        int exp_err;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int pv_cnt = 0;
    int last_rise_t = 0;
    int last_fall_t = 0;
    int stall_t = 0;
    int shape_err = 0;
    logic prev_rise = 1'b0;
    logic prev_fall = 1'b0;
    logic prev_pv = 1'b0;
    logic prev_stall = 1'b0;
    logic [CNT_W-1:0] cap_period = '0;
    logic [CNT_W-1:0] cap_high = '0;
    logic cap_in_range = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({rise_pulse, fall_pulse, period_valid, in_range, stalled, err_seen, period, high_time});
    endfunction

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rise_pulse) begin
                if (prev_rise) shape_err++;
                rise_cnt++;
                last_rise_t = cyc;
            end
            if (fall_pulse) begin
                if (prev_fall) shape_err++;
                fall_cnt++;
                last_fall_t = cyc;
            end
            if (rise_pulse && fall_pulse) shape_err++;
            if (period_valid) begin
                if (prev_pv) shape_err++;
                pv_cnt++;
                cap_period   = period;
                cap_high     = high_time;
                cap_in_range = in_range;
            end
            if (stalled && !prev_stall) stall_t = cyc;
            prev_rise  = rise_pulse;
            prev_fall  = fall_pulse;
            prev_pv    = period_valid;
            prev_stall = stalled;
        end
    endtask

    initial begin
        int pv0;
        int r0;
        int f0;

        // Each row starts with a rise that publishes the previous row's waveform.
        vecs[0] = '{10, 10, 0,  0,  0, 0, 0};
        vecs[1] = '{11, 11, 1, 20, 10, 1, 0};
        vecs[2] = '{ 9,  9, 1, 22, 11, 1, 0};
        vecs[3] = '{12, 11, 1, 18,  9, 1, 0};
        vecs[4] = '{ 9,  8, 1, 23, 12, 0, 1};
        vecs[5] = '{13, 13, 1, 17,  9, 0, 1};
        vecs[6] = '{10, 10, 1, 26, 13, 0, 1};

        rst    = 1'b1;
        clk_in = 1'b0;
        clr    = 1'b0;
        #22;
        rst = 1'b0;
        step(3);
        check("reset_idle_outs", all_outs(), 0);

        for (int i = 0; i < 7; i++) begin
            pv0    = pv_cnt;
            clk_in = 1'b1;
            step(vecs[i].hi);
            clk_in = 1'b0;
            step(vecs[i].lo);
            check($sformatf("row%0d_pv_count", i), pv_cnt - pv0, vecs[i].exp_pv);
            if (vecs[i].exp_pv != 0) begin
                check($sformatf("row%0d_period", i), int'(cap_period), vecs[i].exp_period);
                check($sformatf("row%0d_high_time", i), int'(cap_high), vecs[i].exp_high);
                check($sformatf("row%0d_in_range", i), int'(cap_in_range), vecs[i].exp_in_range);
            end
            check($sformatf("row%0d_err_seen", i), int'(err_seen), vecs[i].exp_err);
            check($sformatf("row%0d_rise_to_fall", i), last_fall_t - last_rise_t, vecs[i].hi);
        end

        // Back to nominal after an error: in range again, error stays sticky.
        clk_in = 1'b1;
        pv0    = pv_cnt;
        step(3);
        check("nominal_pv", pv_cnt - pv0, 1);
        check("nominal_period", int'(cap_period), 20);
        check("nominal_high_time", int'(cap_high), 10);
        check("nominal_in_range", int'(cap_in_range), 1);
        check("nominal_err_sticky", int'(err_seen), 1);

        // Stall: low for 70 cycles after a 10-cycle high.
        pv0 = pv_cnt;
        step(7);
        clk_in = 1'b0;
        step(70);
        check("stall_delay", stall_t - last_rise_t, 64);
        check("stall_flag", int'(stalled), 1);
        check("stall_err", int'(err_seen), 1);
        check("stall_no_pv", pv_cnt - pv0, 0);
        check("stall_period_held", int'(period), 20);

        // Recovery: first rise clears stall without publishing, next one measures.
        pv0    = pv_cnt;
        clk_in = 1'b1;
        step(3);
        check("recover_stalled", int'(stalled), 0);
        check("recover_no_pv", pv_cnt - pv0, 0);
        step(7);
        clk_in = 1'b0;
        step(10);
        clk_in = 1'b1;
        pv0    = pv_cnt;
        step(3);
        check("recover_pv", pv_cnt - pv0, 1);
        check("recover_period", int'(cap_period), 20);

        // clr coincides with the cycle a publishing rise would be registered.
        step(7);
        clk_in = 1'b0;
        step(10);
        clk_in = 1'b1;
        step(2);
        clr = 1'b1;
        pv0 = pv_cnt;
        step(1);
        clr = 1'b0;
        check("clr_outs", all_outs(), 0);
        check("clr_no_pv", pv_cnt - pv0, 0);
        step(7);
        clk_in = 1'b0;
        step(10);
        clk_in = 1'b1;
        pv0    = pv_cnt;
        step(3);
        check("clr_first_rise_rise_pulse", int'(rise_pulse), 1);
        check("clr_first_rise_no_pv", pv_cnt - pv0, 0);
        step(7);
        clk_in = 1'b0;
        step(10);
        clk_in = 1'b1;
        pv0    = pv_cnt;
        step(3);
        check("clr_second_rise_pv", pv_cnt - pv0, 1);
        check("clr_second_rise_period", int'(cap_period), 20);
        check("clr_second_rise_high", int'(cap_high), 10);
        check("clr_second_rise_err", int'(err_seen), 0);

        // Stuck high with a sub-cycle low glitch that must not be seen.
        r0 = rise_cnt;
        f0 = fall_cnt;
        step(17);
        #2 clk_in = 1'b0;
        #3 clk_in = 1'b1;
        step(47);
        check("glitch_no_rise", rise_cnt - r0, 0);
        check("glitch_no_fall", fall_cnt - f0, 0);
        check("glitch_stall_delay", stall_t - last_rise_t, 64);
        check("glitch_stalled", int'(stalled), 1);
        check("glitch_err", int'(err_seen), 1);
        check("pulse_shapes", shape_err, 0);

        // Asynchronous reset between clock edges.
        #3 rst = 1'b1;
        #1;
        check("async_reset_outs", all_outs(), 0);
        clk_in = 1'b0;
        #2 rst = 1'b0;
        step(10);
        check("post_reset_quiet_outs", all_outs(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
